wb_commit_stage: RTL and testbench

- Parametrised N-lane writeback/commit stage, the successor to the single-lane writeback stage.
- Sits between the MEM stage and the regfile, CSR and TLB units.
- Retires up to LANES in-order instructions per cycle and masks regfile writes behind the oldest serialising lane.
- Raises one flush per group, with an encoded exception cause, and adds an idle-wait state, a post-flush hold and a retired-instruction counter.

---
 rtl/wb_commit_stage_pkg.sv | 35 +++
 rtl/wb_commit_stage_if.sv | 28 ++
 rtl/wb_commit_stage_excp_cause_enc.sv | 37 +++
 rtl/wb_commit_stage.sv | 136 +++++++++++++
 tb/tb_wb_commit_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_stage_pkg.sv
// wb_commit_stage_pkg: exception bit map, cause codes and FSM encoding for the commit stage
package wb_commit_stage_pkg;
    localparam int EXCP_INT    = 0;
    localparam int EXCP_ADEF   = 1;
    localparam int EXCP_TLBR_F = 2;
    localparam int EXCP_PIF    = 3;
    localparam int EXCP_PPI_F  = 4;
    localparam int EXCP_SYS    = 5;
    localparam int EXCP_BRK    = 6;
    localparam int EXCP_INE    = 7;
    localparam int EXCP_IPE    = 8;
    localparam int EXCP_ALE    = 9;
    localparam int EXCP_ADEM   = 10;
    localparam int EXCP_TLBR_M = 11;
    localparam int EXCP_PME    = 12;
    localparam int EXCP_PPI_M  = 13;
    localparam int EXCP_PIS    = 14;
    localparam int EXCP_PIL    = 15;
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_IPE  = 6'h0e;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;
    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, IDLE = 2'd2} state_t;
endpackage

// File: rtl/wb_commit_stage_if.sv
// wb_commit_stage_if: MEM-to-writeback group bus with its allowin handshake
interface wb_commit_stage_if #(parameter int LANES = 2);
    logic                  ws_allowin;
    logic                  ms_to_ws_valid;
    logic [LANES-1:0]      ms_lane_valid;
    logic [32*LANES-1:0]   ms_pc;
    logic [LANES-1:0]      ms_gr_we;
    logic [5*LANES-1:0]    ms_dest;
    logic [32*LANES-1:0]   ms_result;
    logic [16*LANES-1:0]   ms_excp_num;
    logic [32*LANES-1:0]   ms_error_va;
    logic [LANES-1:0]      ms_ertn;
    logic [LANES-1:0]      ms_csr_we;
    logic [14*LANES-1:0]   ms_csr_idx;
    logic [32*LANES-1:0]   ms_csr_wdata;
    logic [LANES-1:0]      ms_refetch;
    logic [LANES-1:0]      ms_idle;
    modport master (
        input  ws_allowin,
        output ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_excp_num,
               ms_error_va, ms_ertn, ms_csr_we, ms_csr_idx, ms_csr_wdata, ms_refetch, ms_idle
    );
    modport slave (
        output ws_allowin,
        input  ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_excp_num,
               ms_error_va, ms_ertn, ms_csr_we, ms_csr_idx, ms_csr_wdata, ms_refetch, ms_idle
    );
endinterface

// File: rtl/wb_commit_stage_excp_cause_enc.sv
// excp_cause_enc: priority-encodes an exception vector into ecode/esubcode and the faulting VA
module excp_cause_enc
    import wb_commit_stage_pkg::*;
(
    input  logic [15:0] excp_num,
    input  logic [31:0] pc,
    input  logic [31:0] error_va,
    output logic [5:0]  ecode,
    output logic [8:0]  esubcode,
    output logic        va_error,
    output logic [31:0] bad_va,
    output logic        tlbrefill
);
    always_comb begin
        ecode = ECODE_INT;
        esubcode = '0;
        va_error = 1'b0;
        bad_va = '0;
        tlbrefill = 1'b0;
        if (excp_num[EXCP_INT]) ecode = ECODE_INT;
        else if (excp_num[EXCP_ADEF]) begin ecode = ECODE_ADE; esubcode = ESUBCODE_ADEF; {va_error, bad_va} = {1'b1, pc}; end
        else if (excp_num[EXCP_TLBR_F]) begin ecode = ECODE_TLBR; tlbrefill = 1'b1; {va_error, bad_va} = {1'b1, pc}; end
        else if (excp_num[EXCP_PIF]) begin ecode = ECODE_PIF; {va_error, bad_va} = {1'b1, pc}; end
        else if (excp_num[EXCP_PPI_F]) begin ecode = ECODE_PPI; {va_error, bad_va} = {1'b1, pc}; end
        else if (excp_num[EXCP_SYS]) ecode = ECODE_SYS;
        else if (excp_num[EXCP_BRK]) ecode = ECODE_BRK;
        else if (excp_num[EXCP_INE]) ecode = ECODE_INE;
        else if (excp_num[EXCP_IPE]) ecode = ECODE_IPE;
        else if (excp_num[EXCP_ALE]) begin ecode = ECODE_ALE; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_ADEM]) begin ecode = ECODE_ADE; esubcode = ESUBCODE_ADEM; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_TLBR_M]) begin ecode = ECODE_TLBR; tlbrefill = 1'b1; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_PME]) begin ecode = ECODE_PME; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_PPI_M]) begin ecode = ECODE_PPI; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_PIS]) begin ecode = ECODE_PIS; {va_error, bad_va} = {1'b1, error_va}; end
        else if (excp_num[EXCP_PIL]) begin ecode = ECODE_PIL; {va_error, bad_va} = {1'b1, error_va}; end
    end
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: N-lane writeback/commit stage with serialising-lane kill, flush FSM and retire counter
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 48
) (
    input  logic                clk,
    input  logic                reset,
    wb_commit_stage_if.slave    ms,
    input  logic                intr_pending,
    output logic [LANES-1:0]    rf_we,
    output logic [5*LANES-1:0]  rf_waddr,
    output logic [32*LANES-1:0] rf_wdata,
    output logic                excp_flush,
    output logic                ertn_flush,
    output logic                refetch_flush,
    output logic                idle_flush,
    output logic                csr_wr_en,
    output logic [13:0]         wr_csr_addr,
    output logic [31:0]         wr_csr_data,
    output logic [31:0]         csr_era,
    output logic [5:0]          csr_ecode,
    output logic [8:0]          csr_esubcode,
    output logic                va_error,
    output logic [31:0]         bad_va,
    output logic                excp_tlbrefill,
    output logic                idle_wake,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [LANES-1:0]    commit_mask
);
    localparam int KW = LANES > 1 ? $clog2(LANES) : 1;
    state_t state, state_nx;
    logic [3:0] hold_cnt, hold_nx;
    logic ws_valid, ws_allowin, flush_any, fl, has_ser;
    logic [LANES-1:0] lv_in, lv, gr_we, ertn, csr_we, refetch, idle, ser, commit;
    logic [32*LANES-1:0] pc, result, error_va, csr_wdata;
    logic [5*LANES-1:0] dest;
    logic [16*LANES-1:0] excp;
    logic [14*LANES-1:0] csr_idx;
    logic [KW-1:0] k;
    logic [15:0] excp_k;
    logic [CNT_W-1:0] pop;
    assign ms.ws_allowin = ws_allowin;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_valid <= 1'b0;
            {lv, gr_we, ertn, csr_we, refetch, idle} <= '0;
            {pc, result, error_va, csr_wdata, dest, excp, csr_idx} <= '0;
        end else begin
            if (ws_allowin) ws_valid <= ms.ms_to_ws_valid;
            else if (flush_any) ws_valid <= 1'b0;
            if (ms.ms_to_ws_valid && ws_allowin) begin
                lv <= lv_in;
                {gr_we, ertn, csr_we, refetch, idle} <= {ms.ms_gr_we, ms.ms_ertn, ms.ms_csr_we, ms.ms_refetch, ms.ms_idle};
                {pc, result, error_va, csr_wdata} <= {ms.ms_pc, ms.ms_result, ms.ms_error_va, ms.ms_csr_wdata};
                {dest, excp, csr_idx} <= {ms.ms_dest, ms.ms_excp_num, ms.ms_csr_idx};
            end
        end
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lv_in[g] = &ms.ms_lane_valid[g:0];
        assign ser[g] = lv[g] & ((|excp[16*g +: 16]) | ertn[g] | csr_we[g] | refetch[g] | idle[g]);
        assign commit[g] = ws_valid & lv[g] & (!has_ser | (KW'(g) < k) | ((KW'(g) == k) & ~|excp_k));
    end
    always_comb begin
        k = '0;
        has_ser = 1'b0;
        for (int i = LANES - 1; i >= 0; i--)
            if (ser[i]) begin k = KW'(i); has_ser = 1'b1; end
    end
    assign fl = ws_valid & has_ser;
    assign excp_k = fl ? excp[16*k +: 16] : '0;
    always_comb begin
        excp_flush = |excp_k;
        ertn_flush = fl & !excp_flush & ertn[k];
        refetch_flush = fl & !excp_flush & !ertn[k] & (csr_we[k] | refetch[k]);
        idle_flush = fl & !excp_flush & !ertn[k] & !csr_we[k] & !refetch[k] & idle[k];
        flush_any = excp_flush | ertn_flush | refetch_flush | idle_flush;
        csr_wr_en = fl & csr_we[k] & !excp_flush;
        wr_csr_addr = csr_wr_en ? csr_idx[14*k +: 14] : '0;
        wr_csr_data = csr_wr_en ? csr_wdata[32*k +: 32] : '0;
        csr_era = fl ? pc[32*k +: 32] : '0;
        rf_we = commit & gr_we;
        rf_waddr = dest;
        rf_wdata = result;
        commit_mask = commit;
    end
    excp_cause_enc u_enc (
        .excp_num  (excp_k),
        .pc        (pc[32*k +: 32]),
        .error_va  (error_va[32*k +: 32]),
        .ecode     (csr_ecode),
        .esubcode  (csr_esubcode),
        .va_error  (va_error),
        .bad_va    (bad_va),
        .tlbrefill (excp_tlbrefill)
    );
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) pop = pop + CNT_W'(commit[i]);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired_cnt <= '0;
        else retired_cnt <= retired_cnt + pop;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            hold_cnt <= hold_nx;
        end
    end
    always_comb begin
        state_nx = state;
        hold_nx = hold_cnt;
        case (state)
            RUN:
                if (idle_flush) state_nx = IDLE;
                else if (flush_any && HOLD_CYCLES > 0) begin state_nx = HOLD; hold_nx = 4'(HOLD_CYCLES - 1); end
            HOLD:
                if (hold_cnt == 4'd0) state_nx = RUN;
                else hold_nx = hold_cnt - 4'd1;
            IDLE:
                if (intr_pending) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end
    always_comb begin
        ws_allowin = (state == RUN) && !flush_any;
        idle_wake = (state == IDLE) && intr_pending;
    end
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed scenario tests for the 2-lane commit stage, plus a narrow-counter twin for wrap
module tb_wb_commit_stage;
    localparam int L = 2;
    logic clk = 0, reset = 1, intr_pending = 0;
    int total = 0, bad = 0, exp_cnt = 0;
    always #5 clk = ~clk;
    wb_commit_stage_if #(.LANES(L)) m();
    wb_commit_stage_if #(.LANES(L)) s();
    logic [1:0] rf_we, commit_mask, w_rf_we, w_commit_mask, w_retired_cnt;
    logic [9:0] rf_waddr, w_rf_waddr;
    logic [63:0] rf_wdata, w_rf_wdata;
    logic excp_flush, ertn_flush, refetch_flush, idle_flush, csr_wr_en, va_error, excp_tlbrefill, idle_wake;
    logic w_excp_flush, w_ertn_flush, w_refetch_flush, w_idle_flush, w_csr_wr_en, w_va_error, w_excp_tlbrefill, w_idle_wake;
    logic [13:0] wr_csr_addr, w_wr_csr_addr;
    logic [31:0] wr_csr_data, csr_era, bad_va, w_wr_csr_data, w_csr_era, w_bad_va;
    logic [5:0] csr_ecode, w_csr_ecode;
    logic [8:0] csr_esubcode, w_csr_esubcode;
    logic [47:0] retired_cnt;
    assign s.ms_to_ws_valid = m.ms_to_ws_valid;
    assign s.ms_lane_valid  = m.ms_lane_valid;
    assign s.ms_pc          = m.ms_pc;
    assign s.ms_gr_we       = m.ms_gr_we;
    assign s.ms_dest        = m.ms_dest;
    assign s.ms_result      = m.ms_result;
    assign s.ms_excp_num    = m.ms_excp_num;
    assign s.ms_error_va    = m.ms_error_va;
    assign s.ms_ertn        = m.ms_ertn;
    assign s.ms_csr_we      = m.ms_csr_we;
    assign s.ms_csr_idx     = m.ms_csr_idx;
    assign s.ms_csr_wdata   = m.ms_csr_wdata;
    assign s.ms_refetch     = m.ms_refetch;
    assign s.ms_idle        = m.ms_idle;
    wb_commit_stage #(.LANES(L), .HOLD_CYCLES(2), .CNT_W(48)) dut (
        .clk(clk), .reset(reset), .ms(m), .intr_pending(intr_pending),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush), .idle_flush(idle_flush),
        .csr_wr_en(csr_wr_en), .wr_csr_addr(wr_csr_addr), .wr_csr_data(wr_csr_data), .csr_era(csr_era),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .va_error(va_error), .bad_va(bad_va),
        .excp_tlbrefill(excp_tlbrefill), .idle_wake(idle_wake), .retired_cnt(retired_cnt), .commit_mask(commit_mask)
    );
    wb_commit_stage #(.LANES(L), .HOLD_CYCLES(2), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .ms(s), .intr_pending(intr_pending),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .excp_flush(w_excp_flush), .ertn_flush(w_ertn_flush), .refetch_flush(w_refetch_flush), .idle_flush(w_idle_flush),
        .csr_wr_en(w_csr_wr_en), .wr_csr_addr(w_wr_csr_addr), .wr_csr_data(w_wr_csr_data), .csr_era(w_csr_era),
        .csr_ecode(w_csr_ecode), .csr_esubcode(w_csr_esubcode), .va_error(w_va_error), .bad_va(w_bad_va),
        .excp_tlbrefill(w_excp_tlbrefill), .idle_wake(w_idle_wake), .retired_cnt(w_retired_cnt), .commit_mask(w_commit_mask)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clr;
        m.ms_to_ws_valid = 0; m.ms_lane_valid = 0; m.ms_pc = 0; m.ms_gr_we = 0; m.ms_dest = 0;
        m.ms_result = 0; m.ms_excp_num = 0; m.ms_error_va = 0; m.ms_ertn = 0; m.ms_csr_we = 0;
        m.ms_csr_idx = 0; m.ms_csr_wdata = 0; m.ms_refetch = 0; m.ms_idle = 0;
    endtask
    task automatic lane(input int i, input logic [31:0] pc, input logic we, input logic [4:0] dest, input logic [31:0] res);
        m.ms_lane_valid[i] = 1'b1;
        m.ms_pc[32*i +: 32] = pc;
        m.ms_gr_we[i] = we;
        m.ms_dest[5*i +: 5] = dest;
        m.ms_result[32*i +: 32] = res;
    endtask
    task automatic send;
        m.ms_to_ws_valid = 1'b1;
        tick;
        m.ms_to_ws_valid = 1'b0;
    endtask
    task automatic test_reset;
        total++; if (m.ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", m.ws_allowin); end
        total++; if ({rf_we, commit_mask} !== 4'b0) begin bad++; $display("FAIL reset_we_mask got=%b want=0000", {rf_we, commit_mask}); end
        total++; if ({excp_flush, ertn_flush, refetch_flush, idle_flush, csr_wr_en, idle_wake} !== 6'b0) begin bad++; $display("FAIL reset_flush got=%b want=000000", {excp_flush, ertn_flush, refetch_flush, idle_flush, csr_wr_en, idle_wake}); end
        total++; if (retired_cnt !== 48'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retired_cnt); end
    endtask
    task automatic test_clean;
        clr; lane(0, 32'h1000, 1, 5'd4, 32'h11); lane(1, 32'h1004, 1, 5'd5, 32'h22);
        send;
        total++; if ({rf_we, commit_mask} !== 4'b1111) begin bad++; $display("FAIL clean_we_mask got=%b want=1111", {rf_we, commit_mask}); end
        total++; if ({rf_waddr, rf_wdata} !== {5'd5, 5'd4, 32'h22, 32'h11}) begin bad++; $display("FAIL clean_wdata got=%h want=%h", {rf_waddr, rf_wdata}, {5'd5, 5'd4, 32'h22, 32'h11}); end
        total++; if ({excp_flush, ertn_flush, refetch_flush, idle_flush, m.ws_allowin} !== 5'b00001) begin bad++; $display("FAIL clean_flush got=%b want=00001", {excp_flush, ertn_flush, refetch_flush, idle_flush, m.ws_allowin}); end
        exp_cnt += 2;
        tick;
        total++; if (retired_cnt !== 48'(exp_cnt)) begin bad++; $display("FAIL clean_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
    endtask
    task automatic test_noncontig;
        clr; lane(1, 32'h1100, 1, 5'd9, 32'h99);
        send;
        total++; if ({rf_we, commit_mask, excp_flush, ertn_flush, refetch_flush, idle_flush} !== 8'b0) begin bad++; $display("FAIL noncontig got=%b want=00000000", {rf_we, commit_mask, excp_flush, ertn_flush, refetch_flush, idle_flush}); end
        tick;
    endtask
    task automatic test_ale;
        clr; lane(0, 32'h2000, 0, 5'd0, 32'h0); lane(1, 32'h2004, 1, 5'd6, 32'h66);
        m.ms_excp_num[9] = 1'b1; m.ms_error_va[31:0] = 32'h1003;
        send;
        total++; if ({excp_flush, ertn_flush, refetch_flush, idle_flush} !== 4'b1000) begin bad++; $display("FAIL ale_flush got=%b want=1000", {excp_flush, ertn_flush, refetch_flush, idle_flush}); end
        total++; if ({csr_ecode, va_error, bad_va} !== {6'h09, 1'b1, 32'h1003}) begin bad++; $display("FAIL ale_cause got=%h want=%h", {csr_ecode, va_error, bad_va}, {6'h09, 1'b1, 32'h1003}); end
        total++; if ({rf_we, commit_mask, m.ws_allowin} !== 5'b0) begin bad++; $display("FAIL ale_kill got=%b want=00000", {rf_we, commit_mask, m.ws_allowin}); end
        total++; if (csr_era !== 32'h2000) begin bad++; $display("FAIL ale_era got=%h want=2000", csr_era); end
        for (int i = 0; i < 2; i++) begin
            tick;
            total++; if ({m.ws_allowin, excp_flush} !== 2'b00) begin bad++; $display("FAIL ale_hold%0d got=%b want=00", i, {m.ws_allowin, excp_flush}); end
        end
        tick;
        total++; if (m.ws_allowin !== 1'b1) begin bad++; $display("FAIL ale_release got=%b want=1", m.ws_allowin); end
    endtask
    task automatic test_csr;
        clr; lane(0, 32'h3000, 1, 5'd3, 32'h33); lane(1, 32'h3004, 0, 5'd0, 32'h0);
        m.ms_csr_we[1] = 1'b1; m.ms_csr_idx[27:14] = 14'h0; m.ms_csr_wdata[63:32] = 32'h5;
        send;
        total++; if ({rf_we, commit_mask} !== 4'b0111) begin bad++; $display("FAIL csr_we_mask got=%b want=0111", {rf_we, commit_mask}); end
        total++; if ({csr_wr_en, wr_csr_addr, wr_csr_data} !== {1'b1, 14'h0, 32'h5}) begin bad++; $display("FAIL csr_write got=%h want=%h", {csr_wr_en, wr_csr_addr, wr_csr_data}, {1'b1, 14'h0, 32'h5}); end
        total++; if ({excp_flush, ertn_flush, refetch_flush, idle_flush} !== 4'b0010) begin bad++; $display("FAIL csr_flush got=%b want=0010", {excp_flush, ertn_flush, refetch_flush, idle_flush}); end
        total++; if (csr_era !== 32'h3004) begin bad++; $display("FAIL csr_era got=%h want=3004", csr_era); end
        exp_cnt += 2;
        tick; tick; tick;
        total++; if (m.ws_allowin !== 1'b1) begin bad++; $display("FAIL csr_release got=%b want=1", m.ws_allowin); end
    endtask
    task automatic test_precedence;
        clr; lane(0, 32'h6000, 1, 5'd2, 32'h66); lane(1, 32'h6004, 0, 5'd0, 32'h0);
        m.ms_excp_num[17] = 1'b1; m.ms_ertn[1] = 1'b1;
        send;
        total++; if ({excp_flush, ertn_flush, rf_we, commit_mask} !== 6'b100101) begin bad++; $display("FAIL prec_flush got=%b want=100101", {excp_flush, ertn_flush, rf_we, commit_mask}); end
        total++; if ({csr_ecode, csr_esubcode, va_error, bad_va, csr_era} !== {6'h08, 9'd0, 1'b1, 32'h6004, 32'h6004}) begin bad++; $display("FAIL prec_cause got=%h want=%h", {csr_ecode, csr_esubcode, va_error, bad_va, csr_era}, {6'h08, 9'd0, 1'b1, 32'h6004, 32'h6004}); end
        exp_cnt += 1;
        tick; tick; tick;
        total++; if (retired_cnt !== 48'(exp_cnt)) begin bad++; $display("FAIL prec_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
    endtask
    task automatic test_idle;
        clr; lane(0, 32'h4000, 0, 5'd0, 32'h0); lane(1, 32'h4004, 1, 5'd7, 32'h77);
        m.ms_idle[0] = 1'b1;
        send;
        total++; if ({idle_flush, excp_flush, refetch_flush, rf_we, commit_mask, m.ws_allowin} !== 8'b10000010) begin bad++; $display("FAIL idle_flush got=%b want=10000010", {idle_flush, excp_flush, refetch_flush, rf_we, commit_mask, m.ws_allowin}); end
        exp_cnt += 1;
        for (int i = 0; i < 10; i++) begin
            tick;
            total++; if ({m.ws_allowin, idle_wake, idle_flush} !== 3'b000) begin bad++; $display("FAIL idle_wait%0d got=%b want=000", i, {m.ws_allowin, idle_wake, idle_flush}); end
        end
        intr_pending = 1'b1;
        #1;
        total++; if (idle_wake !== 1'b1) begin bad++; $display("FAIL idle_wake got=%b want=1", idle_wake); end
        tick;
        intr_pending = 1'b0;
        #1;
        total++; if ({m.ws_allowin, idle_wake} !== 2'b10) begin bad++; $display("FAIL idle_exit got=%b want=10", {m.ws_allowin, idle_wake}); end
        total++; if (retired_cnt !== 48'(exp_cnt)) begin bad++; $display("FAIL idle_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
    endtask
    task automatic test_back_to_back;
        clr; lane(0, 32'h5000, 1, 5'd1, 32'h55);
        m.ms_excp_num[2] = 1'b1; m.ms_excp_num[5] = 1'b1;
        send;
        total++; if ({excp_flush, csr_ecode, excp_tlbrefill, va_error, bad_va} !== {1'b1, 6'h3f, 1'b1, 1'b1, 32'h5000}) begin bad++; $display("FAIL b2b_tlbr got=%h want=%h", {excp_flush, csr_ecode, excp_tlbrefill, va_error, bad_va}, {1'b1, 6'h3f, 1'b1, 1'b1, 32'h5000}); end
        clr; lane(0, 32'h5100, 1, 5'd8, 32'hBAD);
        m.ms_to_ws_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            total++; if ({rf_we, m.ws_allowin} !== 3'b000) begin bad++; $display("FAIL b2b_drop%0d got=%b want=000", i, {rf_we, m.ws_allowin}); end
        end
        tick;
        total++; if ({rf_we, m.ws_allowin} !== 3'b001) begin bad++; $display("FAIL b2b_release got=%b want=001", {rf_we, m.ws_allowin}); end
        clr; lane(0, 32'h5200, 1, 5'd9, 32'hC0DE);
        send;
        total++; if ({rf_we, rf_waddr[4:0], rf_wdata[31:0]} !== {2'b01, 5'd9, 32'hC0DE}) begin bad++; $display("FAIL b2b_accept got=%h want=%h", {rf_we, rf_waddr[4:0], rf_wdata[31:0]}, {2'b01, 5'd9, 32'hC0DE}); end
        exp_cnt += 1;
        tick;
        total++; if (retired_cnt !== 48'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
    endtask
    task automatic test_reset_idle;
        clr; lane(0, 32'h7000, 0, 5'd0, 32'h0);
        m.ms_idle[0] = 1'b1;
        send;
        clr;
        tick; tick;
        total++; if (m.ws_allowin !== 1'b0) begin bad++; $display("FAIL rst_idle_pre got=%b want=0", m.ws_allowin); end
        #2;
        reset = 1'b0;
        intr_pending = 1'b1;
        #1;
        total++; if ({m.ws_allowin, idle_wake, idle_flush, commit_mask} !== 5'b10000) begin bad++; $display("FAIL rst_idle_state got=%b want=10000", {m.ws_allowin, idle_wake, idle_flush, commit_mask}); end
        total++; if ({retired_cnt, w_retired_cnt} !== 50'd0) begin bad++; $display("FAIL rst_idle_cnt got=%0d/%0d want=0/0", retired_cnt, w_retired_cnt); end
        intr_pending = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        tick;
    endtask
    task automatic test_wrap;
        clr; lane(0, 32'h8000, 1, 5'd1, 32'h1); lane(1, 32'h8004, 1, 5'd2, 32'h2);
        send; tick;
        clr; lane(0, 32'h8008, 1, 5'd3, 32'h3);
        send; tick;
        exp_cnt += 3;
        total++; if ({w_retired_cnt, retired_cnt} !== {2'd3, 48'd3}) begin bad++; $display("FAIL wrap_pre got=%0d/%0d want=3/3", w_retired_cnt, retired_cnt); end
        clr; lane(0, 32'h800c, 1, 5'd4, 32'h4); lane(1, 32'h8010, 1, 5'd5, 32'h5);
        send; tick;
        exp_cnt += 2;
        total++; if (w_retired_cnt !== 2'd1) begin bad++; $display("FAIL wrap_narrow got=%0d want=1", w_retired_cnt); end
        total++; if (retired_cnt !== 48'(exp_cnt)) begin bad++; $display("FAIL wrap_wide got=%0d want=%0d", retired_cnt, exp_cnt); end
    endtask
    initial begin
        clr;
        #1 reset = 1'b0;
        #2 test_reset;
        @(negedge clk);
        reset = 1'b1;
        tick;
        test_clean;
        test_noncontig;
        test_ale;
        test_csr;
        test_precedence;
        test_idle;
        test_back_to_back;
        test_reset_idle;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
